// File: rtl/fir_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_pkg
// Description : Shared defaults and helpers for the FIR output quantizer.
//               Provides the default widths, rounding shift, FIFO depth and
//               the rounding-constant function.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_out_pkg;

    localparam int c_IN_WIDTH  = 38;
    localparam int c_OUT_WIDTH = 16;
    localparam int c_SHIFT     = 15;
    localparam int c_DEPTH     = 8;

    // Half an output LSB in input units; adding it before the arithmetic
    // shift gives round-half-toward-plus-infinity.
    function automatic longint unsigned round_const(input int shift);
        longint unsigned k;
        k = 64'd0;
        if (shift > 0) begin
            k = 64'd1 << (shift - 1);
        end
        return k;
    endfunction

endpackage : fir_out_pkg
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_fifo
// Description : First-word-fall-through FIFO carrying a quantized sample plus
//               its saturation bit. Full/empty come from an occupancy counter;
//               a write while full is accepted only if the head pops the same
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_fifo
    import fir_out_pkg::*;
#(
    parameter int DataWidth = c_OUT_WIDTH,
    parameter int Depth     = c_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 wr_sat,
    output logic                 full,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DataWidth-1:0] rd_data,
    output logic                 rd_sat
);

    localparam int AddrW = $clog2(Depth);
    localparam int CntW  = AddrW + 1;

    logic [DataWidth:0] mem_q [Depth];
    logic [AddrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q,  count_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic [DataWidth:0] w_head;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CntW'(Depth));
    assign w_pop   = rd_ready & ~w_empty;
    assign w_push  = wr_valid & (~w_full | w_pop);

    // Pointer and occupancy update; pointers wrap naturally as Depth is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(w_push) - CntW'(w_pop);
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
    end

    // Control state, cleared by reset so buffered entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {wr_sat, wr_data};
        end
    end

    // Head entry falls through; forced to zero while empty.
    assign w_head   = w_empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = ~w_empty;
    assign rd_data  = w_head[DataWidth-1:0];
    assign rd_sat   = w_head[DataWidth];
    assign full     = w_full;

endmodule : fir_out_fifo
`default_nettype wire

// File: rtl/fir_out_quant.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_quant
// Description : FIR output quantizer. Rounds the wide FIR result, shifts away
//               the fractional bits, clips to the output range, and buffers
//               the samples in a FWFT FIFO with sticky overflow and a
//               saturating clip counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_quant
    import fir_out_pkg::*;
#(
    parameter int InWidth  = c_IN_WIDTH,
    parameter int OutWidth = c_OUT_WIDTH,
    parameter int Shift    = c_SHIFT,
    parameter int Depth    = c_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inputValid,
    input  logic [InWidth-1:0]  FIR_input,
    output logic                outputValid,
    input  logic                outputReady,
    output logic [OutWidth-1:0] FIR_output,
    output logic                satFlag,
    output logic                overflow,
    output logic [15:0]         satCount
);

    localparam int SumW = InWidth + 1;
    localparam logic [SumW-1:0] c_ROUND = SumW'(round_const(Shift));
    localparam logic signed [SumW-1:0] c_SAT_MAX =
        {{(SumW - OutWidth + 1){1'b0}}, {(OutWidth - 1){1'b1}}};
    localparam logic signed [SumW-1:0] c_SAT_MIN =
        {{(SumW - OutWidth + 1){1'b1}}, {(OutWidth - 1){1'b0}}};

    logic                s1_valid_q, s1_valid_d;
    logic [SumW-1:0]     s1_sum_q,   s1_sum_d;
    logic                s2_valid_q, s2_valid_d;
    logic [OutWidth-1:0] s2_data_q,  s2_data_d;
    logic                s2_sat_q,   s2_sat_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         sat_count_q, sat_count_d;

    logic signed [SumW-1:0] w_shifted;
    logic                   w_fifo_full;
    logic                   w_fifo_valid;
    logic                   w_pop;
    logic                   w_drop;

    // Stage 1: sign-extend and add half an output LSB.
    always_comb begin
        s1_valid_d = inputValid;
        s1_sum_d   = s1_sum_q;
        if (inputValid) begin
            s1_sum_d = {FIR_input[InWidth-1], FIR_input} + c_ROUND;
        end
    end

    assign w_shifted = $signed(s1_sum_q) >>> Shift;

    // Stage 2: drop fractional bits and clip to the signed output range.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            if (w_shifted > c_SAT_MAX) begin
                s2_data_d = c_SAT_MAX[OutWidth-1:0];
                s2_sat_d  = 1'b1;
            end else if (w_shifted < c_SAT_MIN) begin
                s2_data_d = c_SAT_MIN[OutWidth-1:0];
                s2_sat_d  = 1'b1;
            end else begin
                s2_data_d = w_shifted[OutWidth-1:0];
                s2_sat_d  = 1'b0;
            end
        end
    end

    assign w_pop  = w_fifo_valid & outputReady;
    assign w_drop = s2_valid_q & w_fifo_full & ~w_pop;

    // Status counters evaluated at FIFO-write time, dropped samples included.
    always_comb begin
        overflow_d  = overflow_q | w_drop;
        sat_count_d = sat_count_q;
        if (s2_valid_q && s2_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // Pipeline and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            overflow_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            overflow_q  <= overflow_d;
            sat_count_q <= sat_count_d;
        end
    end

    fir_out_fifo #(
        .DataWidth (OutWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .wr_valid (s2_valid_q),
        .wr_data  (s2_data_q),
        .wr_sat   (s2_sat_q),
        .full     (w_fifo_full),
        .rd_valid (w_fifo_valid),
        .rd_ready (outputReady),
        .rd_data  (FIR_output),
        .rd_sat   (satFlag)
    );

    assign outputValid = w_fifo_valid;
    assign overflow    = overflow_q;
    assign satCount    = sat_count_q;

endmodule : fir_out_quant
`default_nettype wire

// File: doc/fir_out_quant.md
FIR_OUT_QUANT -- requirements
Module: fir_out_quant

Interface
REQ-001 Parameter InWidth, default 38, width of the FIR result feeding this stage.
REQ-002 Parameter OutWidth, default 16, width of the quantized output sample.
REQ-003 Parameter Shift, default 15, number of fractional bits discarded by rounding.
REQ-004 Parameter Depth, default 8, number of output FIFO entries; power of two, at least 2.
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port inputValid  input  1  FIR_input carries a valid FIR result this cycle.
REQ-008 Port FIR_input  input  InWidth  signed two's-complement FIR result.
REQ-009 Port outputValid  output  1  head FIFO entry is present on FIR_output.
REQ-010 Port outputReady  input  1  consumer accepts the head entry this cycle.
REQ-011 Port FIR_output  output  OutWidth  signed quantized sample.
REQ-012 Port satFlag  output  1  the sample on FIR_output was clipped.
REQ-013 Port overflow  output  1  sticky; a sample was dropped because the FIFO was full.
REQ-014 Port satCount  output  16  count of clipped samples since reset; saturates at 65535.

Function
REQ-015 Stage 1 (edge N, inputValid=1) SHALL register FIR_input plus 2^(Shift-1) at InWidth+1 bits; round half toward +infinity.
REQ-016 Stage 2 (edge N+1) SHALL arithmetic-shift the stage-1 sum right by Shift and clip to [-2^(OutWidth-1), 2^(OutWidth-1)-1]; it SHALL record a per-sample sat bit when clipping occurs.
REQ-017 At edge N+2 the sample and its sat bit SHALL be written into the FIFO; valid SHALL travel with the data through both stages.
REQ-018 The FIFO SHALL be first-word-fall-through: with the FIFO empty, outputValid rises in the cycle after edge N+2 (latency 3 edges).
REQ-019 Transfer occurs when outputValid and outputReady are both high at a rising edge; the head entry pops.
REQ-020 outputReady while the FIFO is empty SHALL have no effect.
REQ-021 FIR_output and satFlag SHALL hold stable while outputValid=1 and outputReady=0.
REQ-022 A write with the FIFO full and no simultaneous pop SHALL drop the new sample; the count is unchanged and overflow is set until reset.
REQ-023 A write with the FIFO full and a simultaneous pop SHALL succeed; occupancy stays at Depth.
REQ-024 A simultaneous write and pop with the FIFO empty is impossible (outputValid=0); the write proceeds normally.
REQ-025 Pointers SHALL wrap modulo Depth; full and empty are derived from an occupancy counter of $clog2(Depth)+1 bits.
REQ-026 satCount SHALL increment once per clipped sample at FIFO-write time, including dropped samples, and SHALL hold at 65535.
REQ-027 Back-to-back inputValid (one sample per cycle) SHALL be sustained with no bubbles while outputReady=1.

Reset
REQ-028 rst=0 SHALL asynchronously clear the pipeline valid bits, FIFO pointers and occupancy, overflow and satCount.
REQ-029 While rst=0 and after release, outputValid=0, FIR_output=0, satFlag=0, overflow=0, satCount=0 until the first sample arrives.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered samples; FIFO storage contents need not be cleared.

Structure
REQ-031 A shared package fir_out_pkg SHALL hold the default widths, Shift, Depth and the rounding-constant function.
REQ-032 The FIFO SHALL be a sub-module fir_out_fifo (data+sat payload, valid/ready, count, full/empty); rounding, clipping and counters stay in the top.

Verification
REQ-033 Rounding: inputs 32768, 16384, 16383, -16384, -16385, with outputReady=1 -> outputs 1, 1, 0, 0, -1, each 3 edges after input, satFlag=0.
REQ-034 Saturation: inputs 2^37-1 and -2^37 -> outputs 32767 and -32768, satFlag=1 on each, satCount=2.
REQ-035 Backpressure: outputReady=0, 11 consecutive samples 1..11 (scaled by 2^15) -> 8 stored (1..8), 3 dropped, overflow=1; then outputReady=1 -> 1..8 drain in order, one per cycle.
REQ-036 Full with pop: FIFO full, outputReady=1, and a new sample at the FIFO write the same edge -> occupancy stays 8, overflow stays 0, ordering is preserved.
REQ-037 Reset mid-stream: assert rst low for 1 cycle with 5 samples buffered -> outputValid=0 immediately and satCount=0; the next sample appears 3 edges after its input.
REQ-038 Streaming: 100 random samples, one per cycle, outputReady=1 -> output matches the reference model with zero gaps.
